ram_loader: RTL and testbench
=============================

// Module: ram_loader
// PURPOSE
// - Programming-side master for the 16x8 SAP-1 RAM's program port: drives prg_mode, address,
//   prg_data and the write strobe that the RAM samples on the rising edge.
// - Takes a byte stream from a host source (switch panel / UART rx) over valid/ready.
// - Writes bytes to consecutive addresses 0..DEPTH-1, then releases prg_mode so the CPU may run.
// PARAMETERS
// - ADDR_W    4   RAM address width
// - DATA_W    8   RAM word width
// - DEPTH     16  words loaded per session, 1..2**ADDR_W
// - WR_PULSE  1   cycles prg_wr_en is held high per write, >=1
// PORTS
// - clk          in   1       system clock, all state updates on rising edge
// - rst          in   1       asynchronous, active-high reset
// - start        in   1       level-sampled; begins a load session from IDLE or DONE
// - in_valid     in   1       host byte available
// - in_data      in   DATA_W  host byte
// - in_ready     out  1       loader accepts in_data this cycle (transfer = in_valid & in_ready)
// - prg_mode     out  1       selects RAM program path; high for the whole session
// - prg_address  out  ADDR_W  RAM address being programmed
// - prg_data     out  DATA_W  RAM program data
// - prg_wr_en    out  1       RAM write strobe; RAM captures on 0->1
// - busy         out  1       session in progress
// - done         out  1       session complete; held until next start or rst
// - error        out  1       checksum mismatch (see CONFIGURATION)
// BEHAVIOUR
// - Reset values: in_ready=0, prg_mode=0, prg_address=0, prg_data=0, prg_wr_en=0,
//   busy=0, done=0, error=0, state=IDLE. rst mid-session aborts immediately;
//   prg_wr_en goes low asynchronously, so reset never creates a RAM write edge.
// - All outputs are registered. No output is a combinational function of any input.
// - States: IDLE, ACCEPT, SETUP, STROBE, HOLD, DONE.
// - IDLE/DONE: start=1 -> ACCEPT. Same edge: prg_mode=1, busy=1, done=0, error=0,
//   prg_address=0, and the checksum accumulator is cleared.
// - ACCEPT: in_ready=1. On transfer, latch in_data into prg_data and go to SETUP.
//   in_ready falls on that same edge, so exactly one byte is taken per write.
// - SETUP: one cycle; address and data are stable and prg_wr_en=0.
//   This gives one full cycle of setup before the strobe edge.
// - STROBE: prg_wr_en=1 for WR_PULSE cycles, then HOLD.
// - HOLD: one cycle; prg_wr_en=0, address and data unchanged.
//   - If prg_address==DEPTH-1 -> DONE.
//   - Otherwise prg_address+1 -> ACCEPT.
// - Address never wraps: the session ends at DEPTH-1. With DEPTH=2**ADDR_W, no increment past 15.
// - DONE: prg_mode=0, busy=0, done=1. prg_address and prg_data keep their last values.
// - start while busy is ignored. start and in_valid in the same IDLE cycle: no byte is consumed,
//   because in_ready is still 0.
// - in_valid outside ACCEPT is ignored. Host data is only sampled on a transfer.
// - Throughput: WR_PULSE+3 cycles per byte when in_valid is held high.
//   First in_ready occurs 1 cycle after start is sampled.
// CONFIGURATION
// - LOADER_CHECKSUM_EN defined:
//   - After the HOLD of address DEPTH-1, enter CHECK (in_ready=1); no RAM write in CHECK.
//   - On transfer, error = ((sum of DEPTH data bytes + checksum byte) mod 2**DATA_W != 0).
//   - Then go to DONE. done is asserted either way; error is held until next start or rst.
// - LOADER_CHECKSUM_EN undefined: no CHECK state, no accumulator, error tied to 0,
//   HOLD at DEPTH-1 -> DONE.
// TESTING
// - Reset: assert rst mid-STROBE
//   -> prg_wr_en=0 in the same cycle, all outputs at reset values, state IDLE.
// - Full load, DEPTH=16, in_valid held high, bytes 0x00..0x0F
//   -> 16 rising prg_wr_en edges, each with address==data.
//   -> done 1 cycle after the last HOLD; total 1+16*4 cycles for WR_PULSE=1.
// - Backpressure: host drops in_valid for 5 cycles after byte 3
//   -> loader waits in ACCEPT with prg_wr_en=0, no extra writes, address stays 3 until 0xA3 arrives.
// - Setup check: at every prg_wr_en rise, address/data equal their values 1 cycle earlier
//   and stay unchanged through HOLD.
// - Ignored start: pulse start at byte 7 -> session continues; address is not reset to 0.
// - Checksum (macro defined): bytes 0x01 x16 then 0xF0 -> done=1, error=0.
//   Same stream with checksum 0xF1 -> error=1. Macro undefined: error stays 0 throughout.

Source files
------------

// File: rtl/ram_loader.sv
// Program-port master for the SAP-1 16x8 RAM: streams host bytes into addresses 0..DEPTH-1.
// Define LOADER_CHECKSUM_EN to expect a trailing checksum byte and flag mismatches on error.
module ram_loader #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int WR_PULSE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              prg_mode,
  output logic [ADDR_W-1:0] prg_address,
  output logic [DATA_W-1:0] prg_data,
  output logic              prg_wr_en,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int PW = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [PW-1:0]     LAST_PLS  = PW'(WR_PULSE - 1);

  typedef enum logic [2:0] {IDLE, ACCEPT, SETUP, STROBE, HOLD, DONE, CHECK} state_t;

  state_t            state_q, state_d;
  logic              rdy_q, rdy_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_q, wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [PW-1:0]     pcnt_q, pcnt_d;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [DATA_W-1:0] ck_total;
  logic              err_q, err_d;
  assign ck_total = sum_q + in_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      mode_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pcnt_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pcnt_q  <= pcnt_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    rdy_d   = rdy_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pcnt_d  = pcnt_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE, DONE: if (start) begin
        state_d = ACCEPT;
        rdy_d   = 1'b1;
        mode_d  = 1'b1;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        addr_d  = '0;
`ifdef LOADER_CHECKSUM_EN
        sum_d   = '0;
        err_d   = 1'b0;
`endif
      end
      ACCEPT: if (in_valid && rdy_q) begin
        data_d  = in_data;
        rdy_d   = 1'b0;
        state_d = SETUP;
`ifdef LOADER_CHECKSUM_EN
        sum_d   = ck_total;
`endif
      end
      // Address/data have been stable a full cycle before the strobe rises.
      SETUP: begin
        state_d = STROBE;
        wr_d    = 1'b1;
        pcnt_d  = '0;
      end
      STROBE: begin
        if (pcnt_q == LAST_PLS) begin
          state_d = HOLD;
          wr_d    = 1'b0;
        end else begin
          pcnt_d  = pcnt_q + PW'(1);
        end
      end
      HOLD: begin
        if (addr_q == LAST_ADDR) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHECK;
          rdy_d   = 1'b1;
`else
          state_d = DONE;
          mode_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ACCEPT;
          rdy_d   = 1'b1;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: if (in_valid && rdy_q) begin
        err_d   = (ck_total != '0);
        rdy_d   = 1'b0;
        state_d = DONE;
        mode_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = rdy_q;
  assign prg_mode    = mode_q;
  assign prg_address = addr_q;
  assign prg_data    = data_q;
  assign prg_wr_en   = wr_q;
  assign busy        = busy_q;
  assign done        = done_q;
`ifdef LOADER_CHECKSUM_EN
  assign error       = err_q;
`else
  assign error       = 1'b0;
`endif
endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: random host streams checked against a write-order model of the RAM port.
module tb_ram_loader;
  localparam int ADDR_W = 4, DATA_W = 8, DEPTH = 16, WR_PULSE = 1;
`ifdef LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic clk = 1'b0;
  logic rst, start, in_valid;
  logic [DATA_W-1:0] in_data;
  logic in_ready, prg_mode, prg_wr_en, busy, done, error;
  logic [ADDR_W-1:0] prg_address;
  logic [DATA_W-1:0] prg_data;

  int checks = 0, failures = 0;

  // Model: the k-th write of a session lands at address k carrying the k-th host byte.
  logic [7:0] exp_bytes [DEPTH];
  logic [7:0] ck_byte;
  int wr_cnt;
  logic p_wr;
  logic [ADDR_W-1:0] p_addr, r_addr;
  logic [DATA_W-1:0] p_data, r_data;

  always #5 clk = ~clk;

  ram_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .WR_PULSE(WR_PULSE)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .prg_mode(prg_mode), .prg_address(prg_address), .prg_data(prg_data),
    .prg_wr_en(prg_wr_en), .busy(busy), .done(done), .error(error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge and audit the RAM port against the model.
  task automatic tick();
    @(negedge clk);
    if (prg_wr_en && !p_wr) begin
      chk("setup_addr", prg_address, p_addr);
      chk("setup_data", prg_data, p_data);
      if (wr_cnt < DEPTH) begin
        chk("wr_addr", prg_address, wr_cnt);
        chk("wr_data", prg_data, exp_bytes[wr_cnt]);
      end else begin
        chk("extra_write", wr_cnt, DEPTH - 1);
      end
      r_addr = prg_address;
      r_data = prg_data;
      wr_cnt++;
    end
    if (!prg_wr_en && p_wr) begin
      chk("hold_addr", prg_address, r_addr);
      chk("hold_data", prg_data, r_data);
    end
    p_wr = prg_wr_en; p_addr = prg_address; p_data = prg_data;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_mode"},  prg_mode, 0);
    chk({tag, "_addr"},  prg_address, 0);
    chk({tag, "_data"},  prg_data, 0);
    chk({tag, "_wr"},    prg_wr_en, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_err"},   error, 0);
  endtask

  task automatic run_load(input int max_gap, input bit bp, input bit ign, output int cyc);
    int idx, gap, bpc, sum;
    bit st_done, xfer, ign_now;
    logic [DATA_W-1:0] last_data;
    idx = 0; gap = 0; bpc = 0; st_done = 0; wr_cnt = 0;
    last_data = prg_data;
    start = 1; in_valid = 1; in_data = exp_bytes[0] ^ 8'h5A;
    tick();
    start = 0; cyc = 1;
    chk("first_ready", in_ready, 1);
    chk("start_no_consume", prg_data, last_data);
    chk("start_mode", prg_mode, 1);
    chk("start_busy", busy, 1);
    chk("start_done_clr", done, 0);
    chk("start_err_clr", error, 0);
    chk("start_addr", prg_address, 0);
    while (idx < DEPTH + CK && cyc < 3000) begin
      start = 0; ign_now = 0;
      if (bp && idx == 3 && bpc < 5) begin
        in_valid = 0;
        if (in_ready) begin
          chk("bp_addr", prg_address, 3);
          chk("bp_wr", prg_wr_en, 0);
          chk("bp_writes", wr_cnt, 3);
          bpc++;
        end
      end else if (gap > 0) begin
        in_valid = 0; gap--;
      end else begin
        in_valid = 1;
        in_data = (idx < DEPTH) ? exp_bytes[idx] : ck_byte;
      end
      if (ign && !st_done && idx == 7 && in_ready) begin
        start = 1; st_done = 1; ign_now = 1;
      end
      xfer = in_valid && in_ready;
      tick(); cyc++;
      if (ign_now) begin
        chk("ign_start_addr", prg_address, 7);
        chk("ign_start_busy", busy, 1);
      end
      if (xfer) begin idx++; gap = int'($urandom_range(max_gap, 0)); end
    end
    start = 0; in_valid = 0;
    while (!done && cyc < 3000) begin tick(); cyc++; end
    sum = 0;
    for (int i = 0; i < DEPTH; i++) sum += exp_bytes[i];
    chk("done_seen", done, 1);
    chk("wr_count", wr_cnt, DEPTH);
    chk("end_busy", busy, 0);
    chk("end_mode", prg_mode, 0);
    chk("end_ready", in_ready, 0);
    chk("end_addr", prg_address, DEPTH - 1);
    chk("end_data", prg_data, exp_bytes[DEPTH-1]);
    chk("end_err", error, (CK == 1) ? (((sum + ck_byte) % 256) != 0) : 0);
  endtask

  initial begin
    int cyc, idx, sum;
    bit x;
    rst = 1; start = 0; in_valid = 0; in_data = '0;
    p_wr = 0; p_addr = '0; p_data = '0; r_addr = '0; r_data = '0; wr_cnt = 0; ck_byte = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst = 0;
    in_valid = 1; in_data = 8'hEE;
    tick(); tick();
    chk("idle_valid_ignored", prg_data, 0);
    chk("idle_busy", busy, 0);
    in_valid = 0;

    // Full load, in_valid held high, byte i at address i, correct checksum.
    for (int i = 0; i < DEPTH; i++) exp_bytes[i] = 8'(i);
    ck_byte = 8'(256 - ((DEPTH * (DEPTH - 1) / 2) % 256));
    run_load(0, 0, 0, cyc);
    chk("full_cycles", cyc, 1 + DEPTH * (WR_PULSE + 3) + CK);
    repeat (3) tick();
    chk("done_held", done, 1);

    // Backpressure at byte 3 plus a start pulse mid-session.
    for (int i = 0; i < DEPTH; i++) exp_bytes[i] = 8'($urandom);
    exp_bytes[3] = 8'hA3;
    ck_byte = 8'($urandom);
    run_load(0, 1, 1, cyc);

    // Directed checksum streams.
    for (int i = 0; i < DEPTH; i++) exp_bytes[i] = 8'h01;
    ck_byte = 8'hF0;
    run_load(1, 0, 0, cyc);
    ck_byte = 8'hF1;
    run_load(0, 0, 0, cyc);
    repeat (4) tick();
    chk("err_held", error, CK);

    // Random streams with random gaps and good or corrupted checksums.
    for (int s = 0; s < 3; s++) begin
      sum = 0;
      for (int i = 0; i < DEPTH; i++) begin exp_bytes[i] = 8'($urandom); sum += exp_bytes[i]; end
      ck_byte = 8'(256 - (sum % 256));
      if ($urandom_range(1, 0) == 1) ck_byte = ck_byte + 8'($urandom_range(255, 1));
      run_load(3, 0, 0, cyc);
    end

    // Reset during a strobe.
    for (int i = 0; i < DEPTH; i++) exp_bytes[i] = 8'($urandom);
    wr_cnt = 0;
    start = 1; in_valid = 1; in_data = exp_bytes[0];
    tick();
    start = 0; idx = 0;
    for (int c = 0; c < 40 && !(prg_wr_en && idx >= 2); c++) begin
      in_data = exp_bytes[idx];
      x = in_ready;
      tick();
      if (x) idx++;
    end
    chk("reach_strobe", prg_wr_en, 1);
    #2 rst = 1;
    #1 chk_reset_vals("midrst");
    in_valid = 0;
    p_wr = 0;
    tick();
    rst = 0;
    tick(); tick();
    chk("post_rst_idle_ready", in_ready, 0);
    chk("post_rst_idle_busy", busy, 0);
    chk("post_rst_writes", wr_cnt, idx);

    for (int i = 0; i < DEPTH; i++) exp_bytes[i] = 8'(8'hF0 - i);
    sum = 0;
    for (int i = 0; i < DEPTH; i++) sum += exp_bytes[i];
    ck_byte = 8'(256 - (sum % 256));
    run_load(2, 0, 0, cyc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
